// File: rtl/rand_dispatch.sv
// Round-robin arbiter in front of the shared 5-bit LFSR: serves one client at a time,
// rejection-sampling rand_num until it falls below that client's bound (or the try budget runs out).
module rand_dispatch #(
  parameter int NREQ      = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [4:0]        rand_num,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] bound_flat,
  output logic [NREQ-1:0]   grant,
  output logic [4:0]        value,
  output logic              fallback,
  output logic              busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   sel_reg, sel_next;
  logic [5:0]      bnd_reg, bnd_next;
  logic [3:0]      tries_reg, tries_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [4:0]      value_reg, value_next;
  logic            fallback_reg, fallback_next;

  // Bound 0 stands for the full 0..31 range, so widen to 6 bits and map it to 32.
  logic [5:0]      bound_ext [NREQ];
  logic [PW-1:0]   cand [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
      assign bound_ext[gi] = (bound_flat[5*gi +: 5] == 5'd0) ? 6'd32 : {1'b0, bound_flat[5*gi +: 5]};
      assign cand[gi]      = PW'((int'(ptr_reg) + gi) % NREQ);
    end
  endgenerate

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;

  // Scan offsets from the far end down so the lowest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[i];
      end
    end
  end

  logic            accept;
  logic [NREQ-1:0] sel_onehot;

  assign accept     = {1'b0, rand_num} < bnd_reg;
  assign sel_onehot = NREQ'(1) << sel_reg;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    sel_next      = sel_reg;
    bnd_next      = bnd_reg;
    tries_next    = tries_reg;
    grant_next    = '0;
    value_next    = value_reg;
    fallback_next = fallback_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          sel_next   = pick_idx;
          bnd_next   = bound_ext[pick_idx];
          tries_next = '0;
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (!req[sel_reg]) begin
          state_next = IDLE;
        end else if (accept) begin
          value_next    = rand_num;
          fallback_next = 1'b0;
          grant_next    = sel_onehot;
          state_next    = DONE;
        end else if (tries_reg == LAST_TRY) begin
          value_next    = 5'd0;
          fallback_next = 1'b1;
          grant_next    = sel_onehot;
          state_next    = DONE;
        end else begin
          tries_next = tries_reg + 4'd1;
        end
      end
      DONE: begin
        ptr_next   = (sel_reg == PW'(NREQ - 1)) ? '0 : sel_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      sel_reg      <= '0;
      bnd_reg      <= '0;
      tries_reg    <= '0;
      grant_reg    <= '0;
      value_reg    <= 5'd0;
      fallback_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      bnd_reg      <= bnd_next;
      tries_reg    <= tries_next;
      grant_reg    <= grant_next;
      value_reg    <= value_next;
      fallback_reg <= fallback_next;
    end
  end

  assign grant    = grant_reg;
  assign value    = value_reg;
  assign fallback = fallback_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rand_dispatch.sv
// Bench for rand_dispatch: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_rand_dispatch;
  localparam int NREQ      = 4;
  localparam int MAX_TRIES = 8;
  localparam int BW        = 5 * NREQ;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [4:0]      rand_num = 5'd0;
  logic [NREQ-1:0] req = '0;
  logic [BW-1:0]   bound_flat = '0;
  logic [NREQ-1:0] grant;
  logic [4:0]      value;
  logic            fallback;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rand_dispatch #(.NREQ(NREQ), .MAX_TRIES(MAX_TRIES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rand_num   (rand_num),
    .req        (req),
    .bound_flat (bound_flat),
    .grant      (grant),
    .value      (value),
    .fallback   (fallback),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one pending transaction (client, bound, rejected count), plus a grant cycle.
  int              m_ptr, m_sel, m_bnd, m_rejects;
  bit              m_active, m_granting;
  logic [NREQ-1:0] exp_grant;
  logic [4:0]      exp_value;
  bit              exp_fb, exp_busy;

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_bnd = 0; m_rejects = 0;
    m_active = 0; m_granting = 0;
    exp_grant = '0; exp_value = 5'd0; exp_fb = 0; exp_busy = 0;
  endtask

  task automatic deliver(input logic [4:0] v, input bit fb);
    exp_value  = v;
    exp_fb     = fb;
    m_active   = 0;
    m_granting = 1;
    exp_grant  = NREQ'(1) << m_sel;
  endtask

  task automatic model_step();
    exp_grant = '0;
    if (m_granting) begin
      m_ptr      = (m_sel + 1) % NREQ;
      m_granting = 0;
    end else if (m_active) begin
      if (!req[m_sel]) begin
        m_active = 0;
      end else if (int'(rand_num) < m_bnd) begin
        deliver(rand_num, 1'b0);
      end else begin
        m_rejects++;
        if (m_rejects == MAX_TRIES) deliver(5'd0, 1'b1);
      end
    end else if (req != '0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
      m_bnd     = (bound_flat[5*m_sel +: 5] == 5'd0) ? 32 : int'(bound_flat[5*m_sel +: 5]);
      m_rejects = 0;
      m_active  = 1;
    end
    exp_busy = m_active || m_granting;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!resetn) model_reset();
    chk("grant", int'(grant), int'(exp_grant));
    chk("value", int'(value), int'(exp_value));
    chk("fallback", int'(fallback), int'(exp_fb));
    chk("busy", int'(busy), int'(exp_busy));
    if (grant != '0)
      $display("txn cyc=%0d grant=%b value=%0d fallback=%0d", cyc, grant, value, fallback);
    if (resetn) model_step();
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_bound(input int i, input logic [4:0] v);
    bound_flat[5*i +: 5] = v;
  endtask

  logic [NREQ-1:0] gseq [4];
  int              gcyc [4];
  int              ng, start;
  logic [NREQ-1:0] last_g;

  initial begin
    repeat (2) next_cycle();
    at_neg();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_value", int'(value), 0);
    next_cycle(); resetn = 1'b1;
    next_cycle();

    // Single request, accepted on the third sample.
    next_cycle(); req = 4'b0001; set_bound(0, 5'd10);
    next_cycle(); rand_num = 5'd31; at_neg(); chk("t1_busy", int'(busy), 1);
    next_cycle(); rand_num = 5'd12;
    next_cycle(); rand_num = 5'd7;
    next_cycle(); at_neg();
    chk("t1_grant", int'(grant), 1);
    chk("t1_value", int'(value), 7);
    chk("t1_fallback", int'(fallback), 0);
    next_cycle(); req = '0; at_neg(); chk("t1_busy_low", int'(busy), 0);

    // Round robin from ptr=0 with all clients requesting.
    next_cycle(); resetn = 1'b0;
    next_cycle(); resetn = 1'b1;
    next_cycle(); req = 4'b1111; bound_flat = '0; start = cyc; ng = 0; last_g = '0;
    for (int t = 1; t <= 12; t++) begin
      next_cycle(); req = req & ~last_g; last_g = '0; rand_num = 5'($urandom);
      at_neg();
      if (grant != '0 && ng < 4) begin
        gseq[ng] = grant; gcyc[ng] = cyc; ng++; last_g = grant;
      end
    end
    chk("rr_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
      chk("rr_order", int'(gseq[i]), 1 << i);
      chk("rr_spacing", gcyc[i] - ((i == 0) ? start : gcyc[i-1]), (i == 0) ? 2 : 3);
    end

    // Full-range bound accepts 31 on the first sample.
    next_cycle(); req = 4'b0100; bound_flat = '0;
    next_cycle(); rand_num = 5'd31;
    next_cycle(); at_neg();
    chk("t3_grant", int'(grant), 4);
    chk("t3_value", int'(value), 31);
    next_cycle(); req = '0;

    // Fallback after MAX_TRIES rejections.
    next_cycle(); req = 4'b0010; set_bound(1, 5'd1);
    for (int k = 1; k <= MAX_TRIES; k++) begin
      next_cycle(); rand_num = 5'($urandom_range(31, 1));
      at_neg(); chk("t4_no_early_grant", int'(grant), 0);
    end
    next_cycle(); at_neg();
    chk("t4_grant", int'(grant), 2);
    chk("t4_value", int'(value), 0);
    chk("t4_fallback", int'(fallback), 1);
    next_cycle(); req = '0;

    // Abort of client 2; scan must restart at index 2.
    next_cycle(); req = 4'b0100; set_bound(2, 5'd1);
    next_cycle(); rand_num = 5'd5;
    next_cycle(); req = '0;
    next_cycle(); req = 4'b0111; bound_flat = '0; at_neg();
    chk("t5_busy", int'(busy), 0);
    chk("t5_grant", int'(grant), 0);
    chk("t5_fallback_kept", int'(fallback), 1);
    next_cycle(); rand_num = 5'd9;
    next_cycle(); at_neg();
    chk("t5_next_grant", int'(grant), 4);
    chk("t5_next_value", int'(value), 9);
    next_cycle(); req = '0;

    // Reset mid-SAMPLE.
    next_cycle(); req = 4'b0010; set_bound(1, 5'd1);
    next_cycle(); rand_num = 5'd3;
    next_cycle(); rand_num = 5'd4; resetn = 1'b0; at_neg();
    chk("t6_grant", int'(grant), 0);
    chk("t6_value", int'(value), 0);
    chk("t6_busy", int'(busy), 0);
    next_cycle(); resetn = 1'b1; req = 4'b1000; bound_flat = '0;
    next_cycle(); rand_num = 5'd20;
    next_cycle(); at_neg();
    chk("t6_grant_after", int'(grant), 8);
    chk("t6_value_after", int'(value), 20);
    next_cycle(); req = '0;

    // Random traffic: drops, aborts, bound changes and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      rand_num = 5'($urandom);
      if ($urandom_range(9, 0) == 0) bound_flat = BW'($urandom);
      resetn = ($urandom_range(399, 0) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (exp_grant[i] && $urandom_range(1, 0) == 1) req[i] = 1'b0;
        else if (!req[i]) req[i] = ($urandom_range(3, 0) == 0);
        else if ($urandom_range(24, 0) == 0) req[i] = 1'b0;
      end
    end
    next_cycle(); resetn = 1'b1; req = '0;
    repeat (20) next_cycle();
    at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
